// File: rtl/mm_master_initiator_pkg.sv
// Shared definitions for the minimal-memory master protocol initiator.
//  - default port widths and timeout
//  - FSM state type
//  - size-mask helper: bit i of the read mask for an access of `size` bits
package mm_master_initiator_pkg;

  localparam int unsigned MM_ADDR_W  = 7;
  localparam int unsigned MM_DATA_W  = 8;
  localparam int unsigned MM_SIZE_W  = 4;
  localparam int unsigned MM_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mm_state_e;

  // Size 0 and sizes at or beyond the bus width select the full word.
  function automatic logic size_mask_bit(input logic [31:0] size,
                                         input int unsigned bit_idx,
                                         input int unsigned data_w);
    if (size == 32'd0 || size >= data_w) return 1'b1;
    return bit_idx < size;
  endfunction

endpackage

// File: rtl/mm_master_initiator.sv
// mm_master_initiator
//  Initiator end of the minimal-memory master protocol. Accepts one command
//  at a time on a valid/ready stream, performs a single protocol access and
//  returns exactly one response per command.
// Ports
//  clock, reset              rising-edge clock, async active-low reset
//  cmd_valid/ready           command handshake
//  cmd_we/addr/wdata/size    command fields (size in bits)
//  rsp_valid/ready           response handshake
//  rsp_rdata, rsp_err        size-masked read data (0 for writes/errors), timeout flag
//  Mout_*                    protocol request outputs (registered)
//  M_Rdata_ram, M_DataRdy    protocol completion inputs
module mm_master_initiator
  import mm_master_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W  = MM_ADDR_W,
  parameter int unsigned DATA_W  = MM_DATA_W,
  parameter int unsigned SIZE_W  = MM_SIZE_W,
  parameter int unsigned TIMEOUT = MM_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [SIZE_W-1:0] cmd_size,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              Mout_oe_ram,
  output logic              Mout_we_ram,
  output logic [ADDR_W-1:0] Mout_addr_ram,
  output logic [DATA_W-1:0] Mout_Wdata_ram,
  output logic [SIZE_W-1:0] Mout_data_ram_size,
  input  logic [DATA_W-1:0] M_Rdata_ram,
  input  logic              M_DataRdy
);

  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TC_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  mm_state_e         state;
  logic [CNT_W-1:0]  tcnt;
  logic [DATA_W-1:0] rd_mask;

  always_comb begin
    rd_mask = '0;
    for (int unsigned i = 0; i < DATA_W; i++)
      rd_mask[i] = size_mask_bit(32'(Mout_data_ram_size), i, DATA_W);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= ST_IDLE;
      cmd_ready          <= 1'b1;
      rsp_valid          <= 1'b0;
      rsp_rdata          <= '0;
      rsp_err            <= 1'b0;
      Mout_oe_ram        <= 1'b0;
      Mout_we_ram        <= 1'b0;
      Mout_addr_ram      <= '0;
      Mout_Wdata_ram     <= '0;
      Mout_data_ram_size <= '0;
      tcnt               <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            Mout_addr_ram      <= cmd_addr;
            Mout_Wdata_ram     <= cmd_wdata;
            Mout_data_ram_size <= cmd_size;
            Mout_oe_ram        <= ~cmd_we;
            Mout_we_ram        <= cmd_we;
            cmd_ready          <= 1'b0;
            tcnt               <= '0;
            state              <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Completion takes priority over a timeout landing in the same cycle.
          if (M_DataRdy) begin
            rsp_rdata   <= Mout_we_ram ? '0 : (M_Rdata_ram & rd_mask);
            rsp_err     <= 1'b0;
            rsp_valid   <= 1'b1;
            Mout_oe_ram <= 1'b0;
            Mout_we_ram <= 1'b0;
            state       <= ST_RESP;
          end else if (TIMEOUT != 0 && tcnt == TC_LAST) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_valid   <= 1'b1;
            Mout_oe_ram <= 1'b0;
            Mout_we_ram <= 1'b0;
            state       <= ST_RESP;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
